// File: rtl/hilo_div_seq.sv
// rtl/hilo_div_seq.sv - multi-cycle radix-2 restoring divider feeding the HI/LO register pair
// Optional feature macro: HILO_DIV_EARLY_OUT_EN (skip iteration when |dividend| < |divisor|).
module hilo_div_seq #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] DIVZERO_LO = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  output logic             stallreq_o,
  output logic             ready_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_raw_q;
  logic             q_neg_q, r_neg_q;

  logic             s1, s2, accept, early_out, last_run;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_step, quo_step, rem_fin, quo_fin;

  assign s1     = signed_i & opdata1_i[WIDTH-1];
  assign s2     = signed_i & opdata2_i[WIDTH-1];
  assign mag1   = s1 ? -opdata1_i : opdata1_i;
  assign mag2   = s2 ? -opdata2_i : opdata2_i;
  assign accept = start_i & ~annul_i;

`ifdef HILO_DIV_EARLY_OUT_EN
  assign early_out = (mag2 != '0) && (mag1 < mag2);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step: the dividend magnitude is shifted out of quo_q MSB first
  // while quotient bits are shifted in at the bottom.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign rem_fin  = r_neg_q ? -rem_step : rem_step;
  assign quo_fin  = q_neg_q ? -quo_step : quo_step;
  assign last_run = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    hilo_we_o  = 1'b0;
    ready_o    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          stallreq_o = 1'b1;
          if (mag2 == '0)     state_nxt = S_BYZERO;
          else if (early_out) state_nxt = S_DONE;
          else                state_nxt = S_RUN;
        end
      end
      S_BYZERO: begin
        stallreq_o = ~annul_i;
        state_nxt  = annul_i ? S_IDLE : S_DONE;
      end
      S_RUN: begin
        stallreq_o = ~annul_i;
        if (annul_i)       state_nxt = S_IDLE;
        else if (last_run) state_nxt = S_DONE;
      end
      S_DONE: begin
        ready_o   = 1'b1;
        hilo_we_o = ~annul_i;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // hi_o/lo_o are loaded only on the transition into DONE, so they hold between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_raw_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= mag1;
            dvs_q     <= mag2;
            dvd_raw_q <= opdata1_i;
            q_neg_q   <= s1 ^ s2;
            r_neg_q   <= s1;
            if (early_out) begin
              hi_o <= opdata1_i;
              lo_o <= '0;
            end
          end
        end
        S_BYZERO: begin
          if (!annul_i) begin
            hi_o <= dvd_raw_q;
            lo_o <= DIVZERO_LO;
          end
        end
        S_RUN: begin
          if (!annul_i) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt   <= cnt + CW'(1);
            if (last_run) begin
              hi_o <= rem_fin;
              lo_o <= quo_fin;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_seq.sv
// tb/tb_hilo_div_seq.sv - self-checking bench for hilo_div_seq against an arithmetic reference
module tb_hilo_div_seq;

  logic        clk, rst, start, sgn, annul;
  logic [31:0] a, b;
  logic        stallreq, ready, hilo_we;
  logic [31:0] hi, lo;

  int          vectors;
  int          miscompares;
  logic [31:0] last_hi, last_lo;

  hilo_div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .signed_i   (sgn),
    .annul_i    (annul),
    .opdata1_i  (a),
    .opdata2_i  (b),
    .stallreq_o (stallreq),
    .ready_o    (ready),
    .hilo_we_o  (hilo_we),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic (truncating division, remainder takes dividend sign).
  task automatic model(input logic [31:0] da, input logic [31:0] db, input logic ds,
                       output logic [31:0] eh, output logic [31:0] el, output int elat);
    longint sa, sb, q, r, ma, mb;
    if (ds) begin
      sa = longint'($signed(da));
      sb = longint'($signed(db));
    end else begin
      sa = longint'({32'd0, da});
      sb = longint'({32'd0, db});
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (db == 32'd0) begin
      eh   = da;
      el   = 32'hFFFF_FFFF;
      elat = 2;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      eh   = r[31:0];
      el   = q[31:0];
      elat = 33;
`ifdef HILO_DIV_EARLY_OUT_EN
      if (ma < mb) elat = 1;
`endif
    end
  endtask

  task automatic run_div(input logic [31:0] da, input logic [31:0] db, input logic ds);
    logic [31:0] eh, el;
    int          elat, lat;
    logic        stall_bad;
    model(da, db, ds, eh, el, elat);
    @(negedge clk);
    start = 1'b1; sgn = ds; a = da; b = db;
    #1;
    vectors++;
    if (stallreq !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_stall a=%h b=%h s=%0d got=%b want=1", da, db, ds, stallreq);
    end
    lat = 0;
    stall_bad = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (hilo_we === 1'b1) begin
        lat = n;
        break;
      end
      if (stallreq !== 1'b1) stall_bad = 1'b1;
    end
    vectors++;
    if (lat != elat) begin
      miscompares++;
      $display("FAIL latency a=%h b=%h s=%0d got=%0d want=%0d", da, db, ds, lat, elat);
    end
    vectors++;
    if (hi !== eh || lo !== el) begin
      miscompares++;
      $display("FAIL result a=%h b=%h s=%0d got hi=%h lo=%h want hi=%h lo=%h", da, db, ds, hi, lo, eh, el);
    end
    vectors++;
    if (ready !== 1'b1 || stallreq !== 1'b0 || stall_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL done_handshake a=%h b=%h got ready=%b stall=%b stall_gap=%b want 1 0 0",
               da, db, ready, stallreq, stall_bad);
    end
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (hilo_we !== 1'b0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL we_pulse_width a=%h b=%h got we=%b ready=%b want 0 0", da, db, hilo_we, ready);
    end
    last_hi = eh;
    last_lo = el;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (stallreq !== 1'b0 || ready !== 1'b0 || hilo_we !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state got stall=%b ready=%b we=%b hi=%h lo=%h want all 0",
               stallreq, ready, hilo_we, hi, lo);
    end
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
  endtask

  task automatic test_directed();
    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div(32'd5, 32'd0, 1'b0);
    run_div(32'd5, 32'd9, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd0, 1'b1);
    run_div(32'hFFFF_FFFA, 32'd3, 1'b1);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
  endtask

  task automatic test_annul();
    int we_seen;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'hFFFF_FFF0; b = 32'd3;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    vectors++;
    if (stallreq !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_stall_drop got=%b want=0", stallreq);
    end
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    #1;
    vectors++;
    if (stallreq !== 1'b0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_idle got stall=%b ready=%b want 0 0", stallreq, ready);
    end
    we_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_we === 1'b1) we_seen++;
    end
    vectors++;
    if (we_seen != 0 || hi !== last_hi || lo !== last_lo) begin
      miscompares++;
      $display("FAIL annul_no_write got we_count=%0d hi=%h lo=%h want 0 hi=%h lo=%h",
               we_seen, hi, lo, last_hi, last_lo);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd7;
    repeat (5) @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (stallreq !== 1'b0 || ready !== 1'b0 || hilo_we !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset got stall=%b ready=%b we=%b hi=%h lo=%h want all 0",
               stallreq, ready, hilo_we, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    run_div(32'd9, 32'd3, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic        rs;
    for (int i = 0; i < 40; i++) begin
      rs = 1'(($urandom_range(0, 1)));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = ra + $urandom_range(1, 100);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_div(ra, rb, rs);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_annul();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
